// File: rtl/mc_main_ctrl.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/write-back,
// drives datapath selects, ALUop and write enables, and counts retired instructions.
module mc_main_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter int         CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUop,
  output logic [1:0]       PCSrc,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic [3:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BEQ    = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_HALT   = 4'd10;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]       state_q, state_d;
  logic             is_lw_q, is_lw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;

  // Memory handshake: MemRead/MemWrite act as valid and are held steady while
  // mem_ready is low; the access completes in the cycle where both are high.
  always_comb begin
    state_d = state_q;
    is_lw_d = is_lw_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        is_lw_d = (opcode == OP_LW);
        if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
        else if (opcode == OP_RTYPE)            state_d = S_EXEC;
        else if (opcode == OP_BEQ)              state_d = S_BEQ;
        else if (opcode == OP_J)                state_d = S_JUMP;
        else                                    state_d = S_HALT;
      end
      S_MEMADR: state_d = is_lw_q ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWR: if (mem_ready) begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_EXEC:   state_d = S_RWB;
      S_RWB, S_BEQ, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
    cnt_d = retire ? cnt_q + CNT_ONE : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      is_lw_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      is_lw_q <= is_lw_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUop       = 2'b00;
    PCSrc       = 2'b00;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    halted      = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = 2'b10;
      end
      S_RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUop       = 2'b01;
        PCSrc       = 2'b01;
        PCWriteCond = 1'b1;
      end
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
    // Reset abandons any in-flight access immediately, not on the next edge.
    if (rst) begin
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUop       = 2'b00;
      PCSrc       = 2'b00;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      halted      = 1'b0;
    end
  end

  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed bench for mc_main_ctrl: per-cycle state/control vectors for every
// instruction class, halt trap, reset mid-access and 4-bit counter wrap.
module tb_mc_main_ctrl;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // {IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUop,PCSrc,PCWrite,PCWriteCond,halted}
  localparam logic [16:0] C_ZERO   = 17'b0_0_0_0_0_0_0_0_00_00_00_0_0_0;
  localparam logic [16:0] C_FETCH1 = 17'b0_1_0_1_0_0_0_0_01_00_00_1_0_0;
  localparam logic [16:0] C_FETCH0 = 17'b0_1_0_0_0_0_0_0_01_00_00_0_0_0;
  localparam logic [16:0] C_DECODE = 17'b0_0_0_0_0_0_0_0_11_00_00_0_0_0;
  localparam logic [16:0] C_MEMADR = 17'b0_0_0_0_0_0_0_1_10_00_00_0_0_0;
  localparam logic [16:0] C_MEMRD  = 17'b1_1_0_0_0_0_0_0_00_00_00_0_0_0;
  localparam logic [16:0] C_MEMWB  = 17'b0_0_0_0_0_1_1_0_00_00_00_0_0_0;
  localparam logic [16:0] C_MEMWR  = 17'b1_0_1_0_0_0_0_0_00_00_00_0_0_0;
  localparam logic [16:0] C_EXEC   = 17'b0_0_0_0_0_0_0_1_00_10_00_0_0_0;
  localparam logic [16:0] C_RWB    = 17'b0_0_0_0_1_0_1_0_00_00_00_0_0_0;
  localparam logic [16:0] C_BEQ    = 17'b0_0_0_0_0_0_0_1_00_01_01_0_1_0;
  localparam logic [16:0] C_JUMP   = 17'b0_0_0_0_0_0_0_0_00_00_10_1_0_0;
  localparam logic [16:0] C_HALT   = 17'b0_0_0_0_0_0_0_0_00_00_00_0_0_1;

  logic        clk, rst, mem_ready;
  logic [5:0]  opcode;
  logic        IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUop, PCSrc;
  logic        PCWrite, PCWriteCond, halted;
  logic [3:0]  state;
  logic [31:0] instr_count;

  logic        d4_IorD, d4_MemRead, d4_MemWrite, d4_IRWrite, d4_RegDst, d4_MemtoReg;
  logic        d4_RegWrite, d4_ALUSrcA, d4_PCWrite, d4_PCWriteCond, d4_halted;
  logic [1:0]  d4_ALUSrcB, d4_ALUop, d4_PCSrc;
  logic [3:0]  d4_state;
  logic [3:0]  d4_instr_count;

  int n_checks = 0;
  int n_errors = 0;
  int ir_pulses, pc_pulses;
  logic [31:0] exp_cnt;

  mc_main_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUop(ALUop), .PCSrc(PCSrc), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .state(state), .halted(halted), .instr_count(instr_count)
  );

  mc_main_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .IorD(d4_IorD), .MemRead(d4_MemRead), .MemWrite(d4_MemWrite), .IRWrite(d4_IRWrite),
    .RegDst(d4_RegDst), .MemtoReg(d4_MemtoReg), .RegWrite(d4_RegWrite), .ALUSrcA(d4_ALUSrcA),
    .ALUSrcB(d4_ALUSrcB), .ALUop(d4_ALUop), .PCSrc(d4_PCSrc), .PCWrite(d4_PCWrite),
    .PCWriteCond(d4_PCWriteCond), .state(d4_state), .halted(d4_halted),
    .instr_count(d4_instr_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [16:0] ctrl = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                      ALUSrcA, ALUSrcB, ALUop, PCSrc, PCWrite, PCWriteCond, halted};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle: drive mem_ready, check state and control word, advance one edge.
  task automatic vec(input string tag, input logic mr, input logic [3:0] exp_st,
                     input logic [16:0] exp_ctrl);
    mem_ready = mr;
    #1;
    check({tag, " state"}, {28'd0, state}, {28'd0, exp_st});
    check({tag, " ctrl"}, {15'd0, ctrl}, {15'd0, exp_ctrl});
    check({tag, " rd_wr_excl"}, {31'd0, MemRead & MemWrite}, 32'd0);
    ir_pulses += int'(IRWrite);
    pc_pulses += int'(PCWrite);
    step();
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b1; opcode = OP_RTYPE;
    ir_pulses = 0; pc_pulses = 0;
    step();
    #1;
    check("rst ctrl", {15'd0, ctrl}, {15'd0, C_ZERO});
    step();
    check("rst state", {28'd0, state}, 32'd0);
    check("rst count", instr_count, 32'd0);
    rst = 1'b0;

    // R-type, no waits
    vec("r fetch", 1'b1, 4'd0, C_FETCH1);
    vec("r decode", 1'b1, 4'd1, C_DECODE);
    vec("r exec", 1'b1, 4'd6, C_EXEC);
    vec("r rwb", 1'b1, 4'd7, C_RWB);
    exp_cnt = 32'd1;
    check("r count", instr_count, exp_cnt);

    // lw with 3 fetch waits and 2 read waits: 10 cycles
    opcode = OP_LW; ir_pulses = 0; pc_pulses = 0;
    vec("lw fetch w0", 1'b0, 4'd0, C_FETCH0);
    vec("lw fetch w1", 1'b0, 4'd0, C_FETCH0);
    vec("lw fetch w2", 1'b0, 4'd0, C_FETCH0);
    vec("lw fetch", 1'b1, 4'd0, C_FETCH1);
    vec("lw decode", 1'b0, 4'd1, C_DECODE);
    vec("lw memadr", 1'b0, 4'd2, C_MEMADR);
    vec("lw memrd w0", 1'b0, 4'd3, C_MEMRD);
    vec("lw memrd w1", 1'b0, 4'd3, C_MEMRD);
    vec("lw memrd", 1'b1, 4'd3, C_MEMRD);
    vec("lw memwb", 1'b1, 4'd4, C_MEMWB);
    check("lw irwrite pulses", ir_pulses, 32'd1);
    check("lw pcwrite pulses", pc_pulses, 32'd1);
    exp_cnt = 32'd2;
    check("lw count", instr_count, exp_cnt);
    check("lw back to fetch", {28'd0, state}, 32'd0);

    // sw, beq, j with mem_ready held high
    opcode = OP_SW;
    vec("sw fetch", 1'b1, 4'd0, C_FETCH1);
    vec("sw decode", 1'b1, 4'd1, C_DECODE);
    vec("sw memadr", 1'b1, 4'd2, C_MEMADR);
    vec("sw memwr", 1'b1, 4'd5, C_MEMWR);
    check("sw count", instr_count, 32'd3);
    opcode = OP_BEQ;
    vec("beq fetch", 1'b1, 4'd0, C_FETCH1);
    vec("beq decode", 1'b1, 4'd1, C_DECODE);
    vec("beq beq", 1'b1, 4'd8, C_BEQ);
    check("beq count", instr_count, 32'd4);
    opcode = OP_J;
    vec("j fetch", 1'b1, 4'd0, C_FETCH1);
    vec("j decode", 1'b1, 4'd1, C_DECODE);
    vec("j jump", 1'b1, 4'd9, C_JUMP);
    check("j count", instr_count, 32'd5);

    // illegal opcode traps and stays trapped
    opcode = 6'b111111;
    vec("ill fetch", 1'b1, 4'd0, C_FETCH1);
    vec("ill decode", 1'b1, 4'd1, C_DECODE);
    opcode = OP_RTYPE;
    for (int i = 0; i < 20; i++) vec("halt", 1'(i % 2), 4'd10, C_HALT);
    check("halt count", instr_count, 32'd5);
    rst = 1'b1;
    #1;
    check("halt rst ctrl", {15'd0, ctrl}, {15'd0, C_ZERO});
    step();
    check("halt rst state", {28'd0, state}, 32'd0);
    check("halt rst halted", {31'd0, halted}, 32'd0);
    check("halt rst count", instr_count, 32'd0);
    rst = 1'b0;

    // reset while a store is waiting
    opcode = OP_SW;
    vec("rsw fetch", 1'b1, 4'd0, C_FETCH1);
    vec("rsw decode", 1'b1, 4'd1, C_DECODE);
    vec("rsw memadr", 1'b1, 4'd2, C_MEMADR);
    vec("rsw memwr w0", 1'b0, 4'd5, C_MEMWR);
    rst = 1'b1;
    #1;
    check("rsw rst state", {28'd0, state}, 32'd5);
    check("rsw rst memwrite", {31'd0, MemWrite}, 32'd0);
    check("rsw rst ctrl", {15'd0, ctrl}, {15'd0, C_ZERO});
    step();
    check("rsw state", {28'd0, state}, 32'd0);
    check("rsw count", instr_count, 32'd0);
    rst = 1'b0;

    // counter wrap on the 4-bit instance; the 32-bit one keeps counting
    opcode = OP_RTYPE;
    for (int n = 1; n <= 17; n++) begin
      vec("wrap fetch", 1'b1, 4'd0, C_FETCH1);
      vec("wrap decode", 1'b1, 4'd1, C_DECODE);
      vec("wrap exec", 1'b1, 4'd6, C_EXEC);
      vec("wrap rwb", 1'b1, 4'd7, C_RWB);
      check("wrap count4", {28'd0, d4_instr_count}, 32'(n % 16));
      check("wrap count32", instr_count, 32'(n));
    end
    check("wrap 17th count4", {28'd0, d4_instr_count}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
